// File: rtl/jtag_tap_responder_if.sv
// jtag_tap_responder_if
// Groups the JTAG serial pins and the USER register side-band into one
// bundle. The TAP clock (TCK) and reset (TRST) stay as plain module ports.
//   TMS, TDI        : host -> TAP serial control and data
//   TDO, TDO_EN     : TAP -> host serial data and its output enable
//   USER_RDATA      : system -> TAP, value captured into USER
//   USER_WDATA      : TAP -> system, last value written through USER
//   USER_WSTB       : TAP -> system, one-TCK write pulse
//   USER_CSTB       : TAP -> system, one-TCK capture pulse
// modport master : the JTAG host / system side
// modport slave  : the TAP responder
interface jtag_tap_responder_if;
    logic        TMS;
    logic        TDI;
    logic        TDO;
    logic        TDO_EN;
    logic [31:0] USER_RDATA;
    logic [31:0] USER_WDATA;
    logic        USER_WSTB;
    logic        USER_CSTB;

    modport master (
        output TMS, TDI, USER_RDATA,
        input  TDO, TDO_EN, USER_WDATA, USER_WSTB, USER_CSTB
    );

    modport slave (
        input  TMS, TDI, USER_RDATA,
        output TDO, TDO_EN, USER_WDATA, USER_WSTB, USER_CSTB
    );
endinterface

// File: rtl/jtag_tap_responder.sv
// jtag_tap_responder
// IEEE 1149.1 TAP controller with a 5-bit instruction register and three
// data registers: IDCODE (32 bit), USER (32 bit, parallel read/write to the
// system) and BYPASS (1 bit, any unrecognised instruction).
// Ports:
//   TCK  : test clock; state and shift registers advance on the rising edge,
//          TDO/TDO_EN update on the falling edge
//   TRST : asynchronous active-high reset of the whole TAP
//   jtag : serial pins and USER side-band (see jtag_tap_responder_if)
module jtag_tap_responder #(
    parameter logic [4:0]  IR_CODE_IDCODE = 5'h01,
    parameter logic [4:0]  IR_CODE_USER   = 5'h11,
    parameter logic [31:0] IDCODE_VAL     = 32'h1000_1DE5
) (
    input  logic                 TCK,
    input  logic                 TRST,
    jtag_tap_responder_if.slave  jtag
);

    typedef enum logic [3:0] {
        TLR      = 4'd0,
        RTI      = 4'd1,
        SEL_DR   = 4'd2,
        CAP_DR   = 4'd3,
        SHIFT_DR = 4'd4,
        EXIT1_DR = 4'd5,
        PAUSE_DR = 4'd6,
        EXIT2_DR = 4'd7,
        UPD_DR   = 4'd8,
        SEL_IR   = 4'd9,
        CAP_IR   = 4'd10,
        SHIFT_IR = 4'd11,
        EXIT1_IR = 4'd12,
        PAUSE_IR = 4'd13,
        EXIT2_IR = 4'd14,
        UPD_IR   = 4'd15
    } tap_state_t;

    tap_state_t  state_r;
    logic [4:0]  ir_r;
    logic [4:0]  ir_sr_r;
    logic [31:0] dr_sr_r;
    logic [31:0] wdata_r;
    logic        wstb_r;
    logic        cstb_r;
    logic        tdo_r;
    logic        tdo_en_r;

    logic        id_sel_s;
    logic        user_sel_s;
    logic        bypass_sel_s;
    logic [31:0] capture_s;

    // Data register selection and the value it captures
    always_comb begin
        id_sel_s     = (ir_r == IR_CODE_IDCODE);
        user_sel_s   = (ir_r == IR_CODE_USER) && !id_sel_s;
        bypass_sel_s = !id_sel_s && !user_sel_s;
        capture_s    = 32'd0;
        if (id_sel_s) begin
            capture_s = IDCODE_VAL;
        end else if (user_sel_s) begin
            capture_s = jtag.USER_RDATA;
        end else begin
            capture_s = 32'd0;
        end
    end

    // TAP state machine, IR/DR shift stages and USER strobes (rising edge)
    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            state_r <= TLR;
            ir_r    <= IR_CODE_IDCODE;
            ir_sr_r <= 5'd0;
            dr_sr_r <= 32'd0;
            wdata_r <= 32'd0;
            wstb_r  <= 1'b0;
            cstb_r  <= 1'b0;
        end else begin
            wstb_r <= 1'b0;
            cstb_r <= 1'b0;
            case (state_r)
                TLR: begin
                    ir_r    <= IR_CODE_IDCODE;
                    state_r <= jtag.TMS ? TLR : RTI;
                end
                RTI:      state_r <= jtag.TMS ? SEL_DR : RTI;
                SEL_DR:   state_r <= jtag.TMS ? SEL_IR : CAP_DR;
                CAP_DR: begin
                    dr_sr_r <= capture_s;
                    cstb_r  <= user_sel_s;
                    state_r <= jtag.TMS ? EXIT1_DR : SHIFT_DR;
                end
                SHIFT_DR: begin
                    // BYPASS is a single stage: new bit lands directly in bit 0
                    if (bypass_sel_s) begin
                        dr_sr_r <= {31'd0, jtag.TDI};
                    end else begin
                        dr_sr_r <= {jtag.TDI, dr_sr_r[31:1]};
                    end
                    state_r <= jtag.TMS ? EXIT1_DR : SHIFT_DR;
                end
                EXIT1_DR: state_r <= jtag.TMS ? UPD_DR : PAUSE_DR;
                PAUSE_DR: state_r <= jtag.TMS ? EXIT2_DR : PAUSE_DR;
                EXIT2_DR: state_r <= jtag.TMS ? UPD_DR : SHIFT_DR;
                UPD_DR: begin
                    if (user_sel_s) begin
                        wdata_r <= dr_sr_r;
                        wstb_r  <= 1'b1;
                    end else begin
                        wdata_r <= wdata_r;
                    end
                    state_r <= jtag.TMS ? SEL_DR : RTI;
                end
                SEL_IR:   state_r <= jtag.TMS ? TLR : CAP_IR;
                CAP_IR: begin
                    ir_sr_r <= 5'b00001;
                    state_r <= jtag.TMS ? EXIT1_IR : SHIFT_IR;
                end
                SHIFT_IR: begin
                    ir_sr_r <= {jtag.TDI, ir_sr_r[4:1]};
                    state_r <= jtag.TMS ? EXIT1_IR : SHIFT_IR;
                end
                EXIT1_IR: state_r <= jtag.TMS ? UPD_IR : PAUSE_IR;
                PAUSE_IR: state_r <= jtag.TMS ? EXIT2_IR : PAUSE_IR;
                EXIT2_IR: state_r <= jtag.TMS ? UPD_IR : SHIFT_IR;
                UPD_IR: begin
                    ir_r    <= ir_sr_r;
                    state_r <= jtag.TMS ? SEL_DR : RTI;
                end
                default:  state_r <= TLR;
            endcase
        end
    end

    // Serial output stage, updated half a cycle after the shift edge
    always_ff @(negedge TCK or posedge TRST) begin
        if (TRST) begin
            tdo_r    <= 1'b0;
            tdo_en_r <= 1'b0;
        end else begin
            tdo_en_r <= (state_r == SHIFT_DR) || (state_r == SHIFT_IR);
            if (state_r == SHIFT_IR) begin
                tdo_r <= ir_sr_r[0];
            end else if (state_r == SHIFT_DR) begin
                tdo_r <= dr_sr_r[0];
            end else begin
                tdo_r <= 1'b0;
            end
        end
    end

    assign jtag.TDO        = tdo_r;
    assign jtag.TDO_EN     = tdo_en_r;
    assign jtag.USER_WDATA = wdata_r;
    assign jtag.USER_WSTB  = wstb_r;
    assign jtag.USER_CSTB  = cstb_r;

endmodule

// File: tb/tb_jtag_tap_responder.sv
// tb_jtag_tap_responder
// Directed and randomized scans of the TAP, with expected TDO streams and
// USER side effects produced by a bit-queue model of the selected register.
module tb_jtag_tap_responder;
    localparam logic [4:0]  IR_ID  = 5'h01;
    localparam logic [4:0]  IR_USR = 5'h11;
    localparam logic [31:0] ID_VAL = 32'h1000_1DE5;

    logic TCK = 1'b0;
    logic TRST;
    jtag_tap_responder_if jif ();

    jtag_tap_responder #(
        .IR_CODE_IDCODE (IR_ID),
        .IR_CODE_USER   (IR_USR),
        .IDCODE_VAL     (ID_VAL)
    ) dut (
        .TCK  (TCK),
        .TRST (TRST),
        .jtag (jif)
    );

    always #5 TCK = ~TCK;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          wstb_cnt = 0;
    int          cstb_cnt = 0;
    logic [31:0] wdata_at_wstb;
    logic [31:0] exp_wdata;
    logic [4:0]  cur_ir;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One TCK: drive TMS/TDI, report TDO seen by the host at this rising edge
    task automatic tick(input logic tms, input logic tdi, output logic tdo, output logic ten);
        @(negedge TCK);
        #1;
        jif.TMS = tms;
        jif.TDI = tdi;
        tdo = jif.TDO;
        ten = jif.TDO_EN;
        @(posedge TCK);
        #1;
        if (jif.USER_WSTB === 1'b1) begin
            wstb_cnt++;
            wdata_at_wstb = jif.USER_WDATA;
        end
        if (jif.USER_CSTB === 1'b1) cstb_cnt++;
    endtask

    task automatic tms_seq(input logic [7:0] bits, input int n);
        logic d, e;
        for (int i = 0; i < n; i++) tick(bits[i], 1'b0, d, e);
    endtask

    // From Run-Test/Idle: scan n bits through IR or DR, optionally pausing
    // 10 TCKs after pause_at bits, then Update and back to Run-Test/Idle.
    task automatic scan(input bit is_ir, input logic [63:0] din, input int n,
                        input int pause_at, output logic [63:0] dout, output bit en_ok);
        logic d, e;
        bit   brk;
        if (is_ir) tms_seq(8'b0000_0011, 4);
        else       tms_seq(8'b0000_0001, 3);
        en_ok = 1'b1;
        dout  = 64'd0;
        for (int i = 0; i < n; i++) begin
            brk = (pause_at > 0) && (i == pause_at - 1);
            tick((i == n - 1) || brk, din[i], d, e);
            dout[i] = d;
            if (e !== 1'b1) en_ok = 1'b0;
            if (brk) begin
                for (int k = 0; k < 12; k++) begin
                    tick(k == 10, 1'b0, d, e);
                    if (e !== 1'b0 || d !== 1'b0) en_ok = 1'b0;
                end
            end
        end
        tick(1'b1, 1'b0, d, e);
        if (e !== 1'b0 || d !== 1'b0) en_ok = 1'b0;
        tick(1'b0, 1'b0, d, e);
    endtask

    // Reference: shift register as a FIFO of bits, LSB leaves first
    function automatic logic [63:0] model_stream(input logic [31:0] cap, input int len,
            input logic [63:0] din, input int n, output logic [31:0] final_v);
        bit q[$];
        logic [63:0] o;
        o = 64'd0;
        for (int i = 0; i < len; i++) q.push_back(cap[i]);
        for (int i = 0; i < n; i++) begin
            o[i] = q.pop_front();
            q.push_back(din[i]);
        end
        final_v = 32'd0;
        for (int i = 0; i < len; i++) final_v[i] = q[i];
        return o;
    endfunction

    task automatic load_ir(input logic [4:0] code, input string tag);
        logic [63:0] dout;
        bit ok;
        scan(1'b1, {59'd0, code}, 5, 0, dout, ok);
        check({tag, " ir capture"}, dout, 64'h01);
        cur_ir = code;
    endtask

    // Scan the DR under the current IR and check everything against the model
    task automatic dr_check(input logic [63:0] din, input int n, input int pause_at, input string tag);
        logic [63:0] dout, exp_out;
        logic [31:0] cap, fin;
        int          len;
        bit          ok, is_user;
        is_user = (cur_ir == IR_USR);
        if (cur_ir == IR_ID) begin cap = ID_VAL; len = 32; end
        else if (is_user)    begin cap = jif.USER_RDATA; len = 32; end
        else                 begin cap = 32'd0; len = 1; end
        exp_out = model_stream(cap, len, din, n, fin);
        wstb_cnt = 0;
        cstb_cnt = 0;
        scan(1'b0, din, n, pause_at, dout, ok);
        if (is_user) exp_wdata = fin;
        check({tag, " tdo"}, dout, exp_out);
        check({tag, " tdo_en"}, {63'd0, ok}, 64'd1);
        check({tag, " cstb"}, cstb_cnt, is_user ? 64'd1 : 64'd0);
        check({tag, " wstb"}, wstb_cnt, is_user ? 64'd1 : 64'd0);
        check({tag, " wdata"}, jif.USER_WDATA, exp_wdata);
        if (is_user) check({tag, " wdata@wstb"}, wdata_at_wstb, fin);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        d, e;
        logic [63:0] din;
        int          n, p, r;
        logic [4:0]  code;

        // Reset state
        TRST = 1'b1;
        jif.TMS = 1'b1;
        jif.TDI = 1'b0;
        jif.USER_RDATA = 32'd0;
        exp_wdata = 32'd0;
        cur_ir = IR_ID;
        #3;
        check("rst tdo", jif.TDO, 64'd0);
        check("rst tdo_en", jif.TDO_EN, 64'd0);
        check("rst wdata", jif.USER_WDATA, 64'd0);
        check("rst wstb", jif.USER_WSTB, 64'd0);
        check("rst cstb", jif.USER_CSTB, 64'd0);
        #20;
        TRST = 1'b0;

        // IDCODE straight out of reset: TMS 0 then 1,0,0 into Shift-DR
        tms_seq(8'b0, 1);
        tick(1'b0, 1'b0, d, e);
        check("idle tdo", {d, e}, 64'd0);
        dr_check({32'd0, $urandom}, 32, 0, "idcode");

        // IR capture pattern and BYPASS (9 bits shows the 1-bit delay fully)
        load_ir(5'h1F, "bypass");
        dr_check({55'd0, 1'b0, 8'hA5}, 9, 0, "bypass");

        // USER read/write
        load_ir(IR_USR, "user");
        jif.USER_RDATA = 32'hCAFE_F00D;
        dr_check({32'd0, 32'h1234_5678}, 32, 0, "user rw");
        check("user rw value", jif.USER_WDATA, 64'h1234_5678);

        // Pause in the middle of a USER shift
        jif.USER_RDATA = $urandom;
        dr_check({32'd0, $urandom}, 32, 16, "pause");

        // Random instructions, lengths and pauses
        for (int it = 0; it < 10; it++) begin
            r = $urandom_range(0, 2);
            code = (r == 0) ? IR_ID : (r == 1) ? IR_USR : 5'($urandom);
            load_ir(code, "rand");
            jif.USER_RDATA = $urandom;
            n = $urandom_range(1, 40);
            p = (n >= 2 && $urandom_range(0, 1) == 1) ? $urandom_range(1, n - 1) : 0;
            din = {$urandom, $urandom};
            dr_check(din, n, p, "rand");
        end

        // Make sure USER_WDATA is non-zero before the asynchronous reset
        load_ir(IR_USR, "pre-rst");
        jif.USER_RDATA = $urandom;
        dr_check({32'd0, $urandom | 32'h1}, 32, 0, "pre-rst");

        // TRST in the middle of a USER Shift-DR
        tms_seq(8'b0000_0001, 3);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'($urandom), d, e);
        wstb_cnt = 0;
        @(negedge TCK);
        #2;
        TRST = 1'b1;
        jif.TMS = 1'b1;
        #1;
        check("trst tdo", jif.TDO, 64'd0);
        check("trst tdo_en", jif.TDO_EN, 64'd0);
        check("trst wdata", jif.USER_WDATA, 64'd0);
        @(posedge TCK);
        #2;
        TRST = 1'b0;
        exp_wdata = 32'd0;
        cur_ir = IR_ID;
        tms_seq(8'hFF, 3);
        check("trst no wstb", wstb_cnt, 64'd0);
        tms_seq(8'b0, 1);
        dr_check({32'd0, $urandom}, 32, 0, "trst idcode");

        // TMS-only reset from Shift-DR keeps USER_WDATA
        load_ir(IR_USR, "tmsrst");
        jif.USER_RDATA = $urandom;
        dr_check({32'd0, $urandom}, 32, 0, "tmsrst write");
        load_ir(5'h1F, "tmsrst");
        tms_seq(8'b0000_0001, 3);
        tms_seq(8'b0, 3);
        wstb_cnt = 0;
        tms_seq(8'h1F, 5);
        check("tmsrst no wstb", wstb_cnt, 64'd0);
        check("tmsrst wdata", jif.USER_WDATA, exp_wdata);
        cur_ir = IR_ID;
        tms_seq(8'b0, 1);
        dr_check({32'd0, $urandom}, 32, 0, "tmsrst idcode");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
